ysyx_24110006_sram_arb: RTL and testbench

YSYX_24110006_SRAM_ARB -- requirements
Module: ysyx_24110006_sram_arb

---
 rtl/ysyx_24110006_pkg.sv | 18 +
 rtl/ysyx_24110006_rr_arb2.sv | 38 +++
 rtl/ysyx_24110006_sram_arb.sv | 132 +++++++++++++
 tb/tb_ysyx_24110006_sram_arb.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared types and defaults for the IFU/LSU SRAM arbiter.
package ysyx_24110006_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic {
      IFU = 1'b0,
      LSU = 1'b1
   } req_id_e;

   localparam int unsigned DEFAULT_LATENCY = 2;

endpackage

// File: rtl/ysyx_24110006_rr_arb2.sv
// Two-way round-robin grant between IFU and LSU; the winner history
// advances only when a grant is actually accepted.
module ysyx_24110006_rr_arb2
   import ysyx_24110006_pkg::*;
(
   input  logic clk_sys,
   input  logic rst_b,
   input  logic req_ifu,
   input  logic req_lsu,
   input  logic accept,
   output logic grant_lsu
);

   req_id_e last_grant;
   req_id_e grant;

   // With no request pending the grant still points at the next-in-turn
   // requester, so a lone newcomer is re-steered by the single-valid cases.
   always_comb begin
      grant = (last_grant == IFU) ? LSU : IFU;
      if (req_ifu && !req_lsu) begin
         grant = IFU;
      end else if (req_lsu && !req_ifu) begin
         grant = LSU;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         last_grant <= IFU;
      end else if (accept) begin
         last_grant <= grant;
      end
   end

   assign grant_lsu = (grant == LSU);

endmodule

// File: rtl/ysyx_24110006_sram_arb.sv
// Single-outstanding SRAM arbiter: IFU reads and LSU reads/writes share one
// SRAM port, with a programmable wait between the access and the response.
//
// state  | meaning
// IDLE   | ready offered to the arbitration winner; handshake latches request
// ACCESS | one-cycle SRAM strobe from latched values, read data captured
// WAIT   | LATENCY extra cycles counted down
// RESP   | owner's resp_valid held until its resp_ready
module ysyx_24110006_sram_arb
   import ysyx_24110006_pkg::*;
#(
   parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_ifu_req_valid,
   output logic        o_ifu_req_ready,
   input  logic [31:0] i_ifu_addr,
   output logic        o_ifu_resp_valid,
   input  logic        i_ifu_resp_ready,
   output logic [31:0] o_ifu_rdata,
   input  logic        i_lsu_req_valid,
   output logic        o_lsu_req_ready,
   input  logic        i_lsu_wen,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_lsu_wdata,
   input  logic [7:0]  i_lsu_wmask,
   output logic        o_lsu_resp_valid,
   input  logic        i_lsu_resp_ready,
   output logic [31:0] o_lsu_rdata,
   output logic        o_sram_ren,
   output logic        o_sram_wen,
   output logic [31:0] o_sram_raddr,
   output logic [31:0] o_sram_waddr,
   output logic [31:0] o_sram_wdata,
   output logic [7:0]  o_sram_wmask,
   input  logic [31:0] i_sram_rdata
);

   localparam logic [3:0] LAT4 = 4'(LATENCY);

   state_e      state;
   state_e      state_nxt;
   req_id_e     id_q;
   logic        wen_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [7:0]  wmask_q;
   logic [31:0] rdata_q;
   logic [3:0]  cnt;
   logic        grant_lsu;
   logic        hs;
   logic        idle;
   logic        owner_resp_ready;

   ysyx_24110006_rr_arb2 u_arb (
      .clk_sys   (i_clock),
      .rst_b     (i_reset_n),
      .req_ifu   (i_ifu_req_valid),
      .req_lsu   (i_lsu_req_valid),
      .accept    (hs),
      .grant_lsu (grant_lsu)
   );

   assign idle            = (state == IDLE);
   assign o_ifu_req_ready = idle && !grant_lsu;
   assign o_lsu_req_ready = idle && grant_lsu;
   assign hs              = (o_ifu_req_ready && i_ifu_req_valid)
                          || (o_lsu_req_ready && i_lsu_req_valid);
   assign owner_resp_ready = (id_q == LSU) ? i_lsu_resp_ready : i_ifu_resp_ready;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = ACCESS;
         ACCESS:  state_nxt = (LAT4 == 4'd0) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    if (owner_resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         id_q    <= IFU;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         if (hs) begin
            id_q   <= grant_lsu ? LSU : IFU;
            wen_q  <= grant_lsu && i_lsu_wen;
            addr_q <= grant_lsu ? i_lsu_addr : i_ifu_addr;
            // IFU never writes, so its handshake leaves write data/mask alone.
            if (grant_lsu) begin
               wdata_q <= i_lsu_wdata;
               wmask_q <= i_lsu_wmask;
            end
         end
         if (state == ACCESS) begin
            rdata_q <= wen_q ? '0 : i_sram_rdata;
            cnt     <= LAT4 - 4'd1;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   assign o_sram_ren   = (state == ACCESS) && !wen_q;
   assign o_sram_wen   = (state == ACCESS) && wen_q;
   assign o_sram_raddr = addr_q;
   assign o_sram_waddr = addr_q;
   assign o_sram_wdata = wdata_q;
   assign o_sram_wmask = wmask_q;

   assign o_ifu_resp_valid = (state == RESP) && (id_q == IFU);
   assign o_lsu_resp_valid = (state == RESP) && (id_q == LSU);
   assign o_ifu_rdata      = o_ifu_resp_valid ? rdata_q : '0;
   assign o_lsu_rdata      = o_lsu_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_24110006_sram_arb.sv
// Self-checking bench for the IFU/LSU SRAM arbiter: directed scenarios plus a
// randomized arbitration/response run against a transaction-level model.
module tb_ysyx_24110006_sram_arb;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_valid, ifu_resp_ready;
   logic [31:0] ifu_addr;
   logic        lsu_valid, lsu_wen, lsu_resp_ready;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [7:0]  lsu_wmask;

   logic        ifu_ready, ifu_rvalid, lsu_ready, lsu_rvalid;
   logic [31:0] ifu_rdata, lsu_rdata;
   logic        s_ren, s_wen;
   logic [31:0] s_raddr, s_waddr, s_wdata, s_rdata;
   logic [7:0]  s_wmask;

   logic        ifu_ready0, ifu_rvalid0, lsu_ready0, lsu_rvalid0;
   logic [31:0] ifu_rdata0, lsu_rdata0;
   logic        s_ren0, s_wen0;
   logic [31:0] s_raddr0, s_waddr0, s_wdata0, s_rdata0;
   logic [7:0]  s_wmask0;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_last_lsu;
   int dual_cnt = 0;

   typedef struct {
      longint      t;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } strobe_t;
   strobe_t sq[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] sram_f(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign s_rdata  = s_ren  ? sram_f(s_raddr)  : 32'h0BAD_0BAD;
   assign s_rdata0 = s_ren0 ? sram_f(s_raddr0) : 32'h0BAD_0BAD;

   ysyx_24110006_sram_arb #(.LATENCY(LAT)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_ifu_req_valid(ifu_valid), .o_ifu_req_ready(ifu_ready), .i_ifu_addr(ifu_addr),
      .o_ifu_resp_valid(ifu_rvalid), .i_ifu_resp_ready(ifu_resp_ready), .o_ifu_rdata(ifu_rdata),
      .i_lsu_req_valid(lsu_valid), .o_lsu_req_ready(lsu_ready), .i_lsu_wen(lsu_wen),
      .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
      .o_lsu_resp_valid(lsu_rvalid), .i_lsu_resp_ready(lsu_resp_ready), .o_lsu_rdata(lsu_rdata),
      .o_sram_ren(s_ren), .o_sram_wen(s_wen), .o_sram_raddr(s_raddr), .o_sram_waddr(s_waddr),
      .o_sram_wdata(s_wdata), .o_sram_wmask(s_wmask), .i_sram_rdata(s_rdata)
   );

   ysyx_24110006_sram_arb #(.LATENCY(0)) dut0 (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_ifu_req_valid(ifu_valid), .o_ifu_req_ready(ifu_ready0), .i_ifu_addr(ifu_addr),
      .o_ifu_resp_valid(ifu_rvalid0), .i_ifu_resp_ready(ifu_resp_ready), .o_ifu_rdata(ifu_rdata0),
      .i_lsu_req_valid(lsu_valid), .o_lsu_req_ready(lsu_ready0), .i_lsu_wen(lsu_wen),
      .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
      .o_lsu_resp_valid(lsu_rvalid0), .i_lsu_resp_ready(lsu_resp_ready), .o_lsu_rdata(lsu_rdata0),
      .o_sram_ren(s_ren0), .o_sram_wen(s_wen0), .o_sram_raddr(s_raddr0), .o_sram_waddr(s_waddr0),
      .o_sram_wdata(s_wdata0), .o_sram_wmask(s_wmask0), .i_sram_rdata(s_rdata0)
   );

   always @(negedge clk) begin
      if (s_ren && s_wen) dual_cnt++;
      if (s_ren || s_wen)
         sq.push_back(strobe_t'{t: longint'($time), wen: s_wen, addr: (s_wen ? s_waddr : s_raddr),
                                wdata: s_wdata, wmask: s_wmask});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_last_lsu = 1'b0;
   endtask

   task automatic handshake(input bit iv, input bit lv, output bit first_ir, output bit first_lr,
                            output bit g_lsu, output longint t_hs, output bit ok);
      ok = 0; g_lsu = 0; t_hs = 0; first_ir = 0; first_lr = 0;
      @(negedge clk);
      ifu_valid = iv;
      lsu_valid = lv;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (c == 0) begin
            first_ir = ifu_ready;
            first_lr = lsu_ready;
         end
         if ((iv && ifu_ready) || (lv && lsu_ready)) begin
            g_lsu = lv && lsu_ready;
            @(posedge clk);
            t_hs = $time;
            #1;
            ifu_valid = 0;
            lsu_valid = 0;
            ok = 1;
            return;
         end
         @(negedge clk);
      end
      ifu_valid = 0;
      lsu_valid = 0;
   endtask

   task automatic wait_resp(input bit lsu, output int lat, output bit ok);
      ok = 0;
      lat = -1;
      for (int m = 0; m < 40; m++) begin
         @(negedge clk);
         #1;
         if (lsu ? lsu_rvalid : ifu_rvalid) begin
            lat = m + 1;
            ok = 1;
            return;
         end
      end
   endtask

   task automatic accept(input bit lsu);
      if (lsu) lsu_resp_ready = 1'b1;
      else     ifu_resp_ready = 1'b1;
      @(posedge clk);
      #1;
      lsu_resp_ready = 1'b0;
      ifu_resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      ifu_valid = 0; lsu_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
      ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_wen = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({ifu_rvalid, lsu_rvalid, s_ren, s_wen} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b expected 0000", {ifu_rvalid, lsu_rvalid, s_ren, s_wen});
      end
      n_checks++;
      if ({s_raddr, s_waddr, s_wdata, s_wmask} !== 104'h0) begin
         n_fail++;
         $display("FAIL reset_sram_bus: got %h expected 0", {s_raddr, s_waddr, s_wdata, s_wmask});
      end
      n_checks++;
      if ({ifu_rdata, lsu_rdata} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h expected 0", {ifu_rdata, lsu_rdata});
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_last_lsu = 1'b0;
      @(negedge clk);
      ifu_valid = 1; lsu_valid = 1;
      #1;
      n_checks++;
      if ({ifu_ready, lsu_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_first_tie: got ready ifu/lsu=%b expected 01", {ifu_ready, lsu_ready});
      end
      lsu_valid = 0;
      #1;
      n_checks++;
      if ({ifu_ready, lsu_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_ifu_alone: got ready ifu/lsu=%b expected 10", {ifu_ready, lsu_ready});
      end
      ifu_valid = 0;
   endtask

   task automatic test_ifu_read();
      bit ir, lr, g, ok;
      longint t_hs;
      int lat;
      sq.delete();
      ifu_addr = 32'h8000_0000;
      handshake(1, 0, ir, lr, g, t_hs, ok);
      n_checks++;
      if (!ok || g !== 1'b0) begin
         n_fail++;
         $display("FAIL ifu_read_grant: got ok=%0d lsu=%0d expected ok=1 lsu=0", ok, g);
      end
      wait_resp(0, lat, ok);
      n_checks++;
      if (!ok || lat != 2 + LAT) begin
         n_fail++;
         $display("FAIL ifu_read_latency: got %0d expected %0d", lat, 2 + LAT);
      end
      n_checks++;
      if ({ifu_rdata, lsu_rvalid, lsu_rdata} !== {32'hDEAD_BEEF, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL ifu_read_data: got %h/%b/%h expected deadbeef/0/0", ifu_rdata, lsu_rvalid, lsu_rdata);
      end
      accept(0);
      model_last_lsu = 1'b0;
      n_checks++;
      if (sq.size() != 1) begin
         n_fail++;
         $display("FAIL ifu_read_strobes: got %0d strobes expected 1", sq.size());
      end else if ({sq[0].wen, sq[0].addr, (sq[0].t - t_hs + 5) / 10} !== {1'b0, 32'h8000_0000, 64'd1}) begin
         n_fail++;
         $display("FAIL ifu_read_strobe: got wen=%0d addr=%h off=%0d expected wen=0 addr=80000000 off=1",
                  sq[0].wen, sq[0].addr, (sq[0].t - t_hs + 5) / 10);
      end
   endtask

   task automatic test_lsu_write();
      bit ir, lr, g, ok;
      longint t_hs;
      int lat;
      sq.delete();
      lsu_wen = 1; lsu_addr = 32'h8000_0010; lsu_wdata = 32'h1234_5678; lsu_wmask = 8'h0F;
      handshake(0, 1, ir, lr, g, t_hs, ok);
      n_checks++;
      if (!ok || g !== 1'b1) begin
         n_fail++;
         $display("FAIL lsu_write_grant: got ok=%0d lsu=%0d expected ok=1 lsu=1", ok, g);
      end
      wait_resp(1, lat, ok);
      n_checks++;
      if (!ok || lat != 2 + LAT || lsu_rdata !== 32'h0 || ifu_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL lsu_write_resp: got lat=%0d rdata=%h ifu_rv=%b expected lat=%0d rdata=0 ifu_rv=0",
                  lat, lsu_rdata, ifu_rvalid, 2 + LAT);
      end
      accept(1);
      model_last_lsu = 1'b1;
      n_checks++;
      if (sq.size() != 1) begin
         n_fail++;
         $display("FAIL lsu_write_strobes: got %0d strobes expected 1", sq.size());
      end else if ({sq[0].wen, sq[0].addr, sq[0].wdata, sq[0].wmask} !==
                   {1'b1, 32'h8000_0010, 32'h1234_5678, 8'h0F}) begin
         n_fail++;
         $display("FAIL lsu_write_strobe: got wen=%0d addr=%h data=%h mask=%h expected 1/80000010/12345678/0f",
                  sq[0].wen, sq[0].addr, sq[0].wdata, sq[0].wmask);
      end
      lsu_wen = 0;
   endtask

   task automatic test_round_robin();
      bit ir, lr, found, ok, exp_lsu;
      int lat;
      apply_reset();
      ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_0200; lsu_wen = 0;
      ifu_valid = 1; lsu_valid = 1;
      for (int i = 0; i < 4; i++) begin
         found = 0; ir = 0; lr = 0;
         for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #1;
            if (ifu_ready || lsu_ready) begin
               ir = ifu_ready; lr = lsu_ready; found = 1;
            end
         end
         exp_lsu = !model_last_lsu;
         n_checks++;
         if (!found || {ir, lr} !== {!exp_lsu, exp_lsu}) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got ready ifu/lsu=%b expected %b", i, {ir, lr}, {!exp_lsu, exp_lsu});
         end
         model_last_lsu = exp_lsu;
         if (!found) break;
         @(posedge clk);
         wait_resp(lr, lat, ok);
         n_checks++;
         if (!ok || (lr ? lsu_rdata : ifu_rdata) !== sram_f(lr ? lsu_addr : ifu_addr)) begin
            n_fail++;
            $display("FAIL rr_data[%0d]: got %h expected %h", i, (lr ? lsu_rdata : ifu_rdata),
                     sram_f(lr ? lsu_addr : ifu_addr));
         end
         accept(lr);
      end
      ifu_valid = 0; lsu_valid = 0;
   endtask

   task automatic test_resp_stall();
      bit ir, lr, g, ok;
      longint t_hs;
      int lat;
      logic [31:0] exp;
      sq.delete();
      lsu_wen = 0; lsu_addr = 32'h8000_0040;
      exp = sram_f(32'h8000_0040);
      handshake(0, 1, ir, lr, g, t_hs, ok);
      ifu_addr = 32'h8000_0080;
      ifu_valid = 1;
      wait_resp(1, lat, ok);
      n_checks++;
      if (!ok || lsu_rdata !== exp) begin
         n_fail++;
         $display("FAIL stall_first_resp: got ok=%0d rdata=%h expected %h", ok, lsu_rdata, exp);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if ({lsu_rvalid, lsu_rdata, ifu_ready, lsu_ready, s_ren, s_wen} !== {1'b1, exp, 4'b0000}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got rv=%b rdata=%h rdy=%b%b strobes=%b%b", c, lsu_rvalid,
                     lsu_rdata, ifu_ready, lsu_ready, s_ren, s_wen);
         end
      end
      accept(1);
      @(negedge clk);
      #1;
      n_checks++;
      if ({ifu_ready, lsu_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_held_request: got ready ifu/lsu=%b expected 10", {ifu_ready, lsu_ready});
      end
      @(posedge clk);
      #1 ifu_valid = 0;
      wait_resp(0, lat, ok);
      n_checks++;
      if (!ok || lat != 2 + LAT || ifu_rdata !== sram_f(32'h8000_0080)) begin
         n_fail++;
         $display("FAIL stall_held_resp: got lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, ifu_rdata,
                  2 + LAT, sram_f(32'h8000_0080));
      end
      accept(0);
      model_last_lsu = 1'b0;
      n_checks++;
      if (sq.size() != 2) begin
         n_fail++;
         $display("FAIL stall_strobe_count: got %0d expected 2", sq.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ir, lr, g, ok;
      longint t_hs;
      int lat;
      sq.delete();
      ifu_addr = 32'h8000_0300;
      handshake(1, 0, ir, lr, g, t_hs, ok);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_last_lsu = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if ({ifu_rvalid, lsu_rvalid} !== 2'b00 || sq.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_quiet[%0d]: got rv=%b%b strobes=%0d expected 00 and 1", c,
                     ifu_rvalid, lsu_rvalid, sq.size());
         end
      end
      ifu_addr = 32'h8000_0304;
      handshake(1, 0, ir, lr, g, t_hs, ok);
      n_checks++;
      if (!ok || {ir, lr} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_mid_ready: got ok=%0d ready=%b expected 10", ok, {ir, lr});
      end
      wait_resp(0, lat, ok);
      n_checks++;
      if (!ok || lat != 2 + LAT || ifu_rdata !== sram_f(32'h8000_0304)) begin
         n_fail++;
         $display("FAIL reset_mid_after: got lat=%0d rdata=%h expected lat=%0d rdata=%h", lat, ifu_rdata,
                  2 + LAT, sram_f(32'h8000_0304));
      end
      accept(0);
      model_last_lsu = 1'b0;
   endtask

   task automatic test_random();
      bit ir, lr, g, ok, iv, lv, exp_g, exp_wen;
      longint t_hs;
      int lat, hold, pat;
      logic [31:0] exp_addr, exp_rdata;
      logic [65:0] got_resp, exp_resp;
      for (int it = 0; it < 24; it++) begin
         sq.delete();
         pat = $urandom_range(1, 3);
         iv = pat[0]; lv = pat[1];
         ifu_addr  = $urandom;
         lsu_addr  = $urandom;
         lsu_wdata = $urandom;
         lsu_wen   = 1'($urandom_range(0, 1));
         lsu_wmask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         hold      = $urandom_range(0, 3);
         exp_g     = (iv && lv) ? !model_last_lsu : lv;
         exp_wen   = exp_g && lsu_wen;
         exp_addr  = exp_g ? lsu_addr : ifu_addr;
         exp_rdata = exp_wen ? 32'h0 : sram_f(exp_addr);
         exp_resp  = {1'b1, exp_rdata, 1'b0, 32'h0};
         handshake(iv, lv, ir, lr, g, t_hs, ok);
         n_checks++;
         if (!ok || {ir, lr} !== {!exp_g, exp_g}) begin
            n_fail++;
            $display("FAIL rand_grant[%0d]: got ok=%0d ready=%b expected %b", it, ok, {ir, lr}, {!exp_g, exp_g});
         end
         model_last_lsu = exp_g;
         if (!ok) continue;
         wait_resp(exp_g, lat, ok);
         n_checks++;
         if (!ok || lat != 2 + LAT) begin
            n_fail++;
            $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, 2 + LAT);
         end
         for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
               @(negedge clk);
               #1;
            end
            got_resp = exp_g ? {lsu_rvalid, lsu_rdata, ifu_rvalid, ifu_rdata}
                             : {ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata};
            n_checks++;
            if (got_resp !== exp_resp) begin
               n_fail++;
               $display("FAIL rand_resp[%0d.%0d]: got %h expected %h", it, h, got_resp, exp_resp);
            end
         end
         accept(exp_g);
         n_checks++;
         if (sq.size() != 1) begin
            n_fail++;
            $display("FAIL rand_strobe_count[%0d]: got %0d expected 1", it, sq.size());
         end else if ({sq[0].wen, sq[0].addr, (sq[0].t - t_hs + 5) / 10} !== {exp_wen, exp_addr, 64'd1} ||
                      (exp_wen && {sq[0].wdata, sq[0].wmask} !== {lsu_wdata, lsu_wmask})) begin
            n_fail++;
            $display("FAIL rand_strobe[%0d]: got wen=%0d addr=%h data=%h mask=%h expected wen=%0d addr=%h data=%h mask=%h",
                     it, sq[0].wen, sq[0].addr, sq[0].wdata, sq[0].wmask, exp_wen, exp_addr, lsu_wdata, lsu_wmask);
         end
      end
      n_checks++;
      if (dual_cnt != 0) begin
         n_fail++;
         $display("FAIL dual_strobe: got %0d cycles with ren and wen expected 0", dual_cnt);
      end
   endtask

   task automatic test_latency0();
      longint hs_q[$];
      longint rv_q[$];
      apply_reset();
      ifu_addr = 32'h8000_0500;
      lsu_valid = 0;
      ifu_valid = 1;
      ifu_resp_ready = 1;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         #1;
         if (ifu_ready0) hs_q.push_back(longint'($time));
         if (ifu_rvalid0) begin
            rv_q.push_back(longint'($time));
            n_checks++;
            if (ifu_rdata0 !== sram_f(32'h8000_0500)) begin
               n_fail++;
               $display("FAIL lat0_data: got %h expected %h", ifu_rdata0, sram_f(32'h8000_0500));
            end
         end
      end
      ifu_valid = 0;
      ifu_resp_ready = 0;
      n_checks++;
      if (hs_q.size() != 5 || rv_q.size() != 5) begin
         n_fail++;
         $display("FAIL lat0_count: got hs=%0d resp=%0d expected 5 and 5", hs_q.size(), rv_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ((rv_q[i] - hs_q[i]) / 10 != 2) begin
               n_fail++;
               $display("FAIL lat0_latency[%0d]: got %0d cycles expected 2", i, (rv_q[i] - hs_q[i]) / 10);
            end
            if (i > 0) begin
               n_checks++;
               if ((hs_q[i] - hs_q[i-1]) / 10 != 3) begin
                  n_fail++;
                  $display("FAIL lat0_period[%0d]: got %0d cycles expected 3", i, (hs_q[i] - hs_q[i-1]) / 10);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ifu_read();
      test_lsu_write();
      test_round_robin();
      test_resp_stall();
      test_reset_mid();
      test_random();
      test_latency0();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
